// File: rtl/bus_ram.sv
// bus_ram: CPU-side RAM with optional wait states, a write-protected address window,
// a saturating commit counter and a free-running debug snoop port.
module bus_ram #(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 8,
   parameter int                WAIT_STATES = 0,
   parameter logic [ADDR_W-1:0] RO_BASE     = '1,
   parameter logic [ADDR_W-1:0] RO_LIMIT    = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ab,
   input  logic [DATA_W-1:0] dout,
   input  logic              we,
   output logic [DATA_W-1:0] di,
   output logic              rdy,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       wr_count,
   output logic              prot_err
);
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   localparam logic [3:0] NWAIT = 4'(WAIT_STATES);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   state_t            r_state, w_state_nxt;
   logic [3:0]        r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0] r_ab, w_addr;
   logic [DATA_W-1:0] r_do, w_wdata, r_di, r_dbg;
   logic [15:0]       r_wr_count;
   logic              r_we, r_prot_err, w_we, w_fire, w_prot, w_commit;
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fire      = 1'b0;
      if (r_state == S_IDLE) begin
         w_fire = (NWAIT == 4'd0);
         if (NWAIT != 4'd0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = NWAIT;
         end
      end else begin
         w_cnt_nxt = r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            w_fire      = 1'b1;
            w_state_nxt = S_IDLE;
         end
      end
   end
   // zero-wait accesses use the live bus; otherwise the values latched at acceptance
   assign w_addr   = (NWAIT == 4'd0) ? ab   : r_ab;
   assign w_wdata  = (NWAIT == 4'd0) ? dout : r_do;
   assign w_we     = (NWAIT == 4'd0) ? we   : r_we;
   assign w_prot   = (w_addr >= RO_BASE) && (w_addr <= RO_LIMIT);
   assign w_commit = w_fire && w_we && !w_prot && !reset;
   assign rdy      = (r_state == S_IDLE);
   assign di       = r_di;
   assign dbg_data = r_dbg;
   assign wr_count = r_wr_count;
   assign prot_err = r_prot_err;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ab       <= '0;
         r_do       <= '0;
         r_we       <= 1'b0;
         r_di       <= '0;
         r_dbg      <= '0;
         r_wr_count <= '0;
         r_prot_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dbg   <= r_mem[dbg_addr];
         if (r_state == S_IDLE) begin
            r_ab <= ab;
            r_do <= dout;
            r_we <= we;
         end
         if (w_fire) r_di <= (w_we && !w_prot) ? w_wdata : r_mem[w_addr];
         if (w_commit && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
         if (w_fire && w_we && w_prot) r_prot_err <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (w_commit) r_mem[w_addr] <= w_wdata;
   end
endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: three bus_ram instances (0, 2 and 3 wait states) checked against a
// reference memory model and a queue of expected read data.
module tb_bus_ram;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0]  sb[$];
   logic [7:0]  exp_d;
   logic [7:0]  mdl0 [logic [15:0]];
   logic [15:0] mcnt0 = '0;
   logic        rst0, we0, rdy0, perr0, rst2, we2, rdy2, perr2, rst3, we3, rdy3, perr3;
   logic [15:0] ab0, dbga0, wc0, ab2, dbga2, wc2, ab3, dbga3, wc3;
   logic [7:0]  do0, di0, dbgd0, do2, di2, dbgd2, do3, di3, dbgd3;
   bus_ram #(.WAIT_STATES(0), .RO_BASE(16'hA000), .RO_LIMIT(16'hBFFF)) u0 (
      .clk(clk), .reset(rst0), .ab(ab0), .dout(do0), .we(we0), .di(di0), .rdy(rdy0),
      .dbg_addr(dbga0), .dbg_data(dbgd0), .wr_count(wc0), .prot_err(perr0));
   bus_ram #(.WAIT_STATES(2)) u2 (
      .clk(clk), .reset(rst2), .ab(ab2), .dout(do2), .we(we2), .di(di2), .rdy(rdy2),
      .dbg_addr(dbga2), .dbg_data(dbgd2), .wr_count(wc2), .prot_err(perr2));
   bus_ram #(.WAIT_STATES(3)) u3 (
      .clk(clk), .reset(rst3), .ab(ab3), .dout(do3), .we(we3), .di(di3), .rdy(rdy3),
      .dbg_addr(dbga3), .dbg_data(dbgd3), .wr_count(wc3), .prot_err(perr3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // one zero-wait access on u0; the model records the write and queues the expected di
   task automatic drive0(input logic [15:0] a, input logic w, input logic [7:0] d);
      ab0 = a;
      we0 = w;
      do0 = d;
      if (w && !(a >= 16'hA000 && a <= 16'hBFFF)) begin
         mdl0[a] = d;
         sb.push_back(d);
         if (mcnt0 != 16'hFFFF) mcnt0++;
      end else begin
         sb.push_back(mdl0.exists(a) ? mdl0[a] : 8'hxx);
      end
      tick();
   endtask

   task automatic start2(input logic [15:0] a, input logic w, input logic [7:0] d);
      for (int g = 0; g < 20 && rdy2 !== 1'b1; g++) tick();
      ab2 = a;
      we2 = w;
      do2 = d;
      tick();
   endtask

   task automatic finish2(output int edges);
      edges = 0;
      while (rdy2 !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
      we2 = 1'b0;
   endtask

   task automatic start3(input logic [15:0] a, input logic w, input logic [7:0] d);
      for (int g = 0; g < 20 && rdy3 !== 1'b1; g++) tick();
      ab3 = a;
      we3 = w;
      do3 = d;
      tick();
   endtask

   task automatic finish3(output int edges);
      edges = 0;
      while (rdy3 !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
      we3 = 1'b0;
   endtask

   task automatic test_reset;
      n_tests++; if (di0 !== 8'h00) begin n_fail++; $display("FAIL rst_di0 got=%h exp=00", di0); end
      n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL rst_rdy0 got=%b exp=1", rdy0); end
      n_tests++; if (dbgd0 !== 8'h00) begin n_fail++; $display("FAIL rst_dbg0 got=%h exp=00", dbgd0); end
      n_tests++; if (wc0 !== 16'h0000) begin n_fail++; $display("FAIL rst_wc0 got=%h exp=0000", wc0); end
      n_tests++; if (perr0 !== 1'b0) begin n_fail++; $display("FAIL rst_perr0 got=%b exp=0", perr0); end
      n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL rst_rdy3 got=%b exp=1", rdy3); end
      n_tests++; if (di3 !== 8'h00) begin n_fail++; $display("FAIL rst_di3 got=%h exp=00", di3); end
   endtask

   task automatic test_ws0_rw;
      drive0(16'h0063, 1'b1, 8'h43);
      exp_d = sb.pop_front();
      n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL ws0_wr_di got=%h exp=%h", di0, exp_d); end
      n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL ws0_wr_rdy got=%b exp=1", rdy0); end
      drive0(16'h0063, 1'b0, 8'h00);
      exp_d = sb.pop_front();
      n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL ws0_rd_di got=%h exp=%h", di0, exp_d); end
      n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL ws0_rd_rdy got=%b exp=1", rdy0); end
      n_tests++; if (wc0 !== 16'd1) begin n_fail++; $display("FAIL ws0_wc got=%h exp=0001", wc0); end
      for (int i = 0; i < 6; i++) begin
         drive0(16'h0100 + 16'(i * 37), 1'b1, 8'($urandom));
         exp_d = sb.pop_front();
         n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL ws0_loop_wr%0d got=%h exp=%h", i, di0, exp_d); end
      end
      for (int i = 5; i >= 0; i--) begin
         drive0(16'h0100 + 16'(i * 37), 1'b0, 8'h00);
         exp_d = sb.pop_front();
         n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL ws0_loop_rd%0d got=%h exp=%h", i, di0, exp_d); end
      end
      n_tests++; if (wc0 !== mcnt0) begin n_fail++; $display("FAIL ws0_loop_wc got=%h exp=%h", wc0, mcnt0); end
      we0 = 1'b0;
   endtask

   task automatic test_dbg_collision;
      logic [7:0] old_d;
      old_d = mdl0[16'h0063];
      dbga0 = 16'h0063;
      drive0(16'h0063, 1'b1, 8'h99);
      exp_d = sb.pop_front();
      n_tests++; if (dbgd0 !== old_d) begin n_fail++; $display("FAIL dbg_old got=%h exp=%h", dbgd0, old_d); end
      n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL dbg_wr_di got=%h exp=%h", di0, exp_d); end
      drive0(16'h0063, 1'b0, 8'h00);
      exp_d = sb.pop_front();
      n_tests++; if (dbgd0 !== 8'h99) begin n_fail++; $display("FAIL dbg_new got=%h exp=99", dbgd0); end
      n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL dbg_rd_di got=%h exp=%h", di0, exp_d); end
      we0 = 1'b0;
   endtask

   task automatic test_protect;
      logic [15:0] pa[3] = '{16'hA000, 16'hA123, 16'hBFFF};
      logic [15:0] ca[2] = '{16'h9FFF, 16'hC000};
      logic [7:0]  d;
      n_tests++; if (perr0 !== 1'b0) begin n_fail++; $display("FAIL prot_pre_perr got=%b exp=0", perr0); end
      // contents of the protected window cannot be written, so its power-up values are learned once
      foreach (pa[i]) begin
         ab0 = pa[i];
         we0 = 1'b0;
         tick();
         mdl0[pa[i]] = di0;
      end
      foreach (pa[i]) begin
         d = ~mdl0[pa[i]];
         drive0(pa[i], 1'b1, d);
         exp_d = sb.pop_front();
         n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL prot_wr_di_%h got=%h exp=%h", pa[i], di0, exp_d); end
         n_tests++; if (perr0 !== 1'b1) begin n_fail++; $display("FAIL prot_perr_%h got=%b exp=1", pa[i], perr0); end
         n_tests++; if (wc0 !== mcnt0) begin n_fail++; $display("FAIL prot_wc_%h got=%h exp=%h", pa[i], wc0, mcnt0); end
         drive0(pa[i], 1'b0, 8'h00);
         exp_d = sb.pop_front();
         n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL prot_rd_%h got=%h exp=%h", pa[i], di0, exp_d); end
      end
      foreach (ca[i]) begin
         drive0(ca[i], 1'b1, 8'h5A ^ 8'(i));
         exp_d = sb.pop_front();
         n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL edge_wr_di_%h got=%h exp=%h", ca[i], di0, exp_d); end
         n_tests++; if (wc0 !== mcnt0) begin n_fail++; $display("FAIL edge_wc_%h got=%h exp=%h", ca[i], wc0, mcnt0); end
         drive0(ca[i], 1'b0, 8'h00);
         exp_d = sb.pop_front();
         n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL edge_rd_%h got=%h exp=%h", ca[i], di0, exp_d); end
      end
      we0 = 1'b0;
   endtask

   task automatic test_wait2;
      int edges;
      sb.push_back(8'd90);
      start2(16'h0400, 1'b1, 8'd90);
      n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL ws2_wr_rdy got=%b exp=0", rdy2); end
      finish2(edges);
      exp_d = sb.pop_front();
      n_tests++; if (edges !== 2) begin n_fail++; $display("FAIL ws2_wr_edges got=%0d exp=2", edges); end
      n_tests++; if (di2 !== exp_d) begin n_fail++; $display("FAIL ws2_wr_di got=%h exp=%h", di2, exp_d); end
      sb.push_back(8'h33);
      start2(16'h0401, 1'b1, 8'h33);
      finish2(edges);
      exp_d = sb.pop_front();
      n_tests++; if (di2 !== exp_d) begin n_fail++; $display("FAIL ws2_wr2_di got=%h exp=%h", di2, exp_d); end
      sb.push_back(8'd90);
      start2(16'h0400, 1'b0, 8'h00);
      n_tests++; if (rdy2 !== 1'b0 || di2 !== 8'h33) begin n_fail++; $display("FAIL ws2_rd_e1 rdy=%b di=%h exp rdy=0 di=33", rdy2, di2); end
      ab2 = 16'h0401;
      tick();
      n_tests++; if (rdy2 !== 1'b0 || di2 !== 8'h33) begin n_fail++; $display("FAIL ws2_rd_e2 rdy=%b di=%h exp rdy=0 di=33", rdy2, di2); end
      tick();
      exp_d = sb.pop_front();
      n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL ws2_rd_e3_rdy got=%b exp=1", rdy2); end
      n_tests++; if (di2 !== exp_d) begin n_fail++; $display("FAIL ws2_rd_di got=%h exp=%h", di2, exp_d); end
      we2 = 1'b0;
      dbga2 = 16'h0400;
      tick();
      n_tests++; if (wc2 !== 16'd2) begin n_fail++; $display("FAIL ws2_wc got=%h exp=0002", wc2); end
      n_tests++; if (dbgd2 !== 8'd90 || perr2 !== 1'b0) begin n_fail++; $display("FAIL ws2_dbg got=%h perr=%b exp=5a perr=0", dbgd2, perr2); end
   endtask

   task automatic test_reset_midwait;
      int edges;
      sb.push_back(8'h77);
      start3(16'h000C, 1'b1, 8'h77);
      finish3(edges);
      exp_d = sb.pop_front();
      n_tests++; if (edges !== 3) begin n_fail++; $display("FAIL ws3_wr_edges got=%0d exp=3", edges); end
      n_tests++; if (di3 !== exp_d) begin n_fail++; $display("FAIL ws3_wr_di got=%h exp=%h", di3, exp_d); end
      start3(16'h000C, 1'b1, 8'hEE);
      tick();
      n_tests++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL ws3_midwait_rdy got=%b exp=0", rdy3); end
      #2;
      rst3 = 1'b1;
      we3 = 1'b0;
      ab3 = 16'h0000;
      #1;
      n_tests++; if (rdy3 !== 1'b1 || di3 !== 8'h00) begin n_fail++; $display("FAIL ws3_async_rst rdy=%b di=%h exp rdy=1 di=00", rdy3, di3); end
      n_tests++; if (wc3 !== 16'h0000 || dbgd3 !== 8'h00 || perr3 !== 1'b0) begin n_fail++; $display("FAIL ws3_rst_regs wc=%h dbg=%h perr=%b exp 0", wc3, dbgd3, perr3); end
      tick();
      tick();
      rst3 = 1'b0;
      dbga3 = 16'h000C;
      tick();
      n_tests++; if (dbgd3 !== 8'h77) begin n_fail++; $display("FAIL ws3_mem_kept got=%h exp=77", dbgd3); end
      sb.push_back(8'h77);
      start3(16'h000C, 1'b0, 8'h00);
      finish3(edges);
      exp_d = sb.pop_front();
      n_tests++; if (di3 !== exp_d) begin n_fail++; $display("FAIL ws3_rd_di got=%h exp=%h", di3, exp_d); end
      n_tests++; if (wc3 !== 16'h0000) begin n_fail++; $display("FAIL ws3_wc got=%h exp=0000", wc3); end
   endtask

   task automatic test_saturate;
      int g;
      ab0 = 16'h7000;
      we0 = 1'b1;
      g = 0;
      while (wc0 !== 16'hFFFE && g < 70000) begin
         do0 = g[7:0];
         tick();
         g++;
      end
      n_tests++; if (wc0 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_reach got=%h exp=fffe", wc0); end
      mcnt0 = 16'hFFFE;
      mdl0[16'h7000] = do0;
      for (int i = 0; i < 3; i++) begin
         drive0(16'h7000 + 16'(i), 1'b1, 8'hC0 + 8'(i));
         exp_d = sb.pop_front();
         n_tests++; if (wc0 !== mcnt0) begin n_fail++; $display("FAIL sat_wc%0d got=%h exp=%h", i, wc0, mcnt0); end
         n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL sat_di%0d got=%h exp=%h", i, di0, exp_d); end
      end
      n_tests++; if (wc0 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got=%h exp=ffff", wc0); end
      drive0(16'h7002, 1'b0, 8'h00);
      exp_d = sb.pop_front();
      n_tests++; if (di0 !== exp_d) begin n_fail++; $display("FAIL sat_rd got=%h exp=%h", di0, exp_d); end
      we0 = 1'b0;
   endtask

   initial begin
      {rst0, rst2, rst3} = 3'b111;
      {we0, we2, we3} = 3'b000;
      {ab0, ab2, ab3, dbga0, dbga2, dbga3} = '0;
      {do0, do2, do3} = '0;
      tick();
      test_reset();
      tick();
      {rst0, rst2, rst3} = 3'b000;
      tick();
      test_ws0_rw();
      test_dbg_collision();
      test_protect();
      test_wait2();
      test_reset_midwait();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_ram.md
BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width; memory depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, data word width.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..15, number of stall cycles per access.
REQ-004 SHALL have parameter RO_BASE, default all-ones, first address of the write-protected window.
REQ-005 SHALL have parameter RO_LIMIT, default 0, last address of the write-protected window (inclusive); the window is empty when RO_BASE > RO_LIMIT.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-008 SHALL have port ab, input, ADDR_W bits, CPU address.
REQ-009 SHALL have port do, input, DATA_W bits, CPU write data.
REQ-010 SHALL have port we, input, 1 bit, write enable (1 = write, 0 = read).
REQ-011 SHALL have port di, output, DATA_W bits, registered read data to the CPU.
REQ-012 SHALL have port rdy, output, 1 bit, high when a new access is accepted / previous access complete.
REQ-013 SHALL have port dbg_addr, input, ADDR_W bits, debug snoop read address.
REQ-014 SHALL have port dbg_data, output, DATA_W bits, registered snoop data.
REQ-015 SHALL have port wr_count, output, 16 bits, number of committed writes, saturating.
REQ-016 SHALL have port prot_err, output, 1 bit, sticky flag for a write attempt inside the protected window.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and WAIT; the state is always IDLE when WAIT_STATES = 0.
REQ-018 SHALL accept ab/we/do at a rising edge only while rdy = 1; the CPU holds them stable while rdy = 0.
REQ-019 SHALL, with WAIT_STATES = 0, complete the access at the accepting edge: a read loads di <= mem[ab]; a write commits mem[ab] <= do and loads di <= do; rdy stays 1.
REQ-020 SHALL, with WAIT_STATES = N > 0, latch ab/we/do at the accepting edge, drive rdy to 0, load a countdown with N, and enter WAIT.
REQ-021 SHALL, in WAIT, decrement the countdown each edge; at the edge where it reaches 0, perform the access using the latched values (as REQ-019), set rdy to 1, and return to IDLE; total latency is N+1 edges from acceptance to data.
REQ-022 SHALL hold di between accesses; di changes only at an access completion or on reset.
REQ-023 SHALL suppress a write whose address satisfies RO_BASE <= addr <= RO_LIMIT: memory is unchanged, di <= the current mem[addr], prot_err <= 1, and wr_count is not incremented.
REQ-024 SHALL allow reads anywhere, including inside the protected window.
REQ-025 SHALL increment wr_count on each committed write and saturate at 16'hFFFF.
REQ-026 SHALL update dbg_data <= mem[dbg_addr] every edge, independent of the FSM and of rdy.
REQ-027 SHALL give read-before-write on a collision: when dbg_addr equals a committing write address, dbg_data gets the old contents.
REQ-028 SHALL use address arithmetic that does not wrap or extend; ab is used exactly as ADDR_W bits.

Reset
REQ-029 SHALL, while reset = 1, asynchronously force di = 0, dbg_data = 0, rdy = 1, state = IDLE, countdown = 0, wr_count = 0, prot_err = 0.
REQ-030 SHALL abort any pending access when reset is asserted mid-WAIT; a pending write is never committed.
REQ-031 SHALL leave memory contents unchanged through reset.

Verification
REQ-032 SHALL pass: WAIT_STATES = 0; write 8'h43 to 16'h0063, then read 16'h0063 -> di = 8'h43 at the read-accepting edge, rdy constantly 1, wr_count = 1.
REQ-033 SHALL pass: WAIT_STATES = 2; read 16'h0400 preloaded with 90 -> rdy low for exactly 2 edges, di = 90 at the third edge, ab changes while rdy = 0 are ignored.
REQ-034 SHALL pass: RO_BASE = 16'hA000, RO_LIMIT = 16'hBFFF; write 8'h55 to 16'hA123 (contents 8'h11) -> memory still 8'h11, di = 8'h11, prot_err = 1, wr_count unchanged; the next write to 16'h9FFF commits.
REQ-035 SHALL pass: WAIT_STATES = 3; reset pulsed during WAIT of a write to 16'h000C -> rdy = 1 and di = 0 immediately, mem[16'h000C] unchanged, wr_count = 0.
REQ-036 SHALL pass: dbg_addr = 16'h0063 while a CPU write of 8'h99 commits to 16'h0063 (old value 8'h43) -> dbg_data = 8'h43 that edge and 8'h99 on the next edge.
REQ-037 SHALL pass: force wr_count to 16'hFFFE, perform 3 writes -> wr_count = 16'hFFFF.
